// File: rtl/str_ctrl_pkg.sv
// Shared encodings and default tuning for the symbol timing recovery sequencer.
package str_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACQ   = 2'b01,
    ST_TRACK = 2'b10
  } state_t;

  localparam int DEF_SAMPLE_DIV  = 10;
  localparam int DEF_ER_W        = 32;
  localparam int DEF_LOCK_THRESH = 4096;
  localparam int DEF_ACQ_SYMS    = 256;
  localparam int DEF_LOCK_COUNT  = 64;
  localparam int DEF_LOSS_COUNT  = 16;

  // |er| of a signed er_w-bit value always fits in er_w-1 bits once saturated.
  function automatic int mag_width(input int er_w);
    return er_w - 1;
  endfunction

endpackage

// File: rtl/str_sequencer_if.sv
// Control/status bundle between the STR sequencer and the timing recovery datapath.
interface str_sequencer_if #(
  parameter int ER_W = str_ctrl_pkg::DEF_ER_W
);
  logic                   start;
  logic                   stop;
  logic                   ted_out_en;
  logic signed [ER_W-1:0] er;
  logic                   sample_en;
  logic                   gain_sel;
  logic                   loop_clear;
  logic                   locked;
  logic                   lock_lost;
  logic [1:0]             state;

  modport master (
    output start, stop, ted_out_en, er,
    input  sample_en, gain_sel, loop_clear, locked, lock_lost, state
  );

  modport slave (
    input  start, stop, ted_out_en, er,
    output sample_en, gain_sel, loop_clear, locked, lock_lost, state
  );
endinterface

// File: rtl/str_lock_detector.sv
// Saturating |er| classifier plus symbol/good/bad counters; flags lock and loss
// from post-update counts so the FSM can act on the same ted_out_en cycle.
module str_lock_detector
  import str_ctrl_pkg::*;
#(
  parameter int ER_W        = DEF_ER_W,
  parameter int LOCK_THRESH = DEF_LOCK_THRESH,
  parameter int ACQ_SYMS    = DEF_ACQ_SYMS,
  parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
  parameter int LOSS_COUNT  = DEF_LOSS_COUNT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_idle,
  input  logic                   i_in_acq,
  input  logic                   i_in_track,
  input  logic                   i_clr_acq,
  input  logic                   i_clr_bad,
  input  logic                   i_ted_out_en,
  input  logic signed [ER_W-1:0] i_er,
  output logic                   o_lock_ok,
  output logic                   o_loss_hit
);
  localparam int MW = mag_width(ER_W);
  localparam int SW = $clog2(ACQ_SYMS + 1);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(LOSS_COUNT + 1);

  logic [MW-1:0] w_mag;
  logic          w_good;
  logic [SW-1:0] r_sym, w_sym_nxt;
  logic [GW-1:0] r_good, w_good_nxt;
  logic [BW-1:0] r_bad, w_bad_nxt;

  // Most negative code has all-zero low bits; saturate it to the largest magnitude.
  always_comb begin
    w_mag = i_er[MW-1:0];
    if (i_er[ER_W-1]) begin
      if (i_er[MW-1:0] == '0) w_mag = '1;
      else                    w_mag = (~i_er[MW-1:0]) + MW'(1);
    end
  end

  assign w_good     = (w_mag < MW'(LOCK_THRESH));
  assign w_sym_nxt  = (r_sym == SW'(ACQ_SYMS)) ? r_sym : r_sym + SW'(1);
  assign w_good_nxt = !w_good ? '0 :
                      (r_good == GW'(LOCK_COUNT)) ? r_good : r_good + GW'(1);
  assign w_bad_nxt  = w_good ? '0 :
                      (r_bad == BW'(LOSS_COUNT)) ? r_bad : r_bad + BW'(1);

  assign o_lock_ok  = i_in_acq && i_ted_out_en &&
                      (w_sym_nxt >= SW'(ACQ_SYMS)) && (w_good_nxt == GW'(LOCK_COUNT));
  assign o_loss_hit = i_in_track && i_ted_out_en && (w_bad_nxt == BW'(LOSS_COUNT));

  always_ff @(posedge clk) begin
    if (reset || i_idle || i_clr_acq) begin
      r_sym  <= '0;
      r_good <= '0;
    end else if (i_in_acq && i_ted_out_en) begin
      r_sym  <= w_sym_nxt;
      r_good <= w_good_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i_idle || i_clr_bad) r_bad <= '0;
    else if (i_in_track && i_ted_out_en) r_bad <= w_bad_nxt;
  end

endmodule

// File: rtl/str_sequencer.sv
// Symbol timing recovery run-time controller: sample pacing, gain scheduling, lock FSM.
//   state    | meaning
//   ST_IDLE  | loop held clear, no samples consumed
//   ST_ACQ   | wide loop gains, counting toward lock
//   ST_TRACK | narrow loop gains, watching for loss of lock
module str_sequencer
  import str_ctrl_pkg::*;
#(
  parameter int SAMPLE_DIV  = DEF_SAMPLE_DIV,
  parameter int ER_W        = DEF_ER_W,
  parameter int LOCK_THRESH = DEF_LOCK_THRESH,
  parameter int ACQ_SYMS    = DEF_ACQ_SYMS,
  parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
  parameter int LOSS_COUNT  = DEF_LOSS_COUNT
) (
  input logic            clk,
  input logic            reset,
  str_sequencer_if.slave bus
);
  localparam int DW = $clog2(SAMPLE_DIV);

  state_t        r_state, w_next;
  logic [DW-1:0] r_div, w_div_nxt;
  logic          r_sample_en, r_gain_sel, r_loop_clear, r_locked, r_lock_lost;
  logic          w_lock_ok, w_loss_hit;

  str_lock_detector #(
    .ER_W(ER_W), .LOCK_THRESH(LOCK_THRESH), .ACQ_SYMS(ACQ_SYMS),
    .LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT)
  ) u_lock (
    .clk          (clk),
    .reset        (reset),
    .i_idle       (r_state == ST_IDLE),
    .i_in_acq     (r_state == ST_ACQ),
    .i_in_track   (r_state == ST_TRACK),
    .i_clr_acq    ((r_state != ST_ACQ) && (w_next == ST_ACQ)),
    .i_clr_bad    ((r_state != ST_TRACK) && (w_next == ST_TRACK)),
    .i_ted_out_en (bus.ted_out_en),
    .i_er         (bus.er),
    .o_lock_ok    (w_lock_ok),
    .o_loss_hit   (w_loss_hit)
  );

  // stop overrides everything, including lock/loss decisions in the same cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_next = ST_ACQ;
      ST_ACQ:   if (w_lock_ok) w_next = ST_TRACK;
      ST_TRACK: if (w_loss_hit) w_next = ST_ACQ;
      default:  w_next = ST_IDLE;
    endcase
    if (bus.stop) w_next = ST_IDLE;
  end

  // Pacer sits at 0 throughout IDLE so the first ACQ cycle starts a fresh period.
  always_comb begin
    w_div_nxt = '0;
    if ((r_state != ST_IDLE) && (w_next != ST_IDLE) && (r_div != DW'(SAMPLE_DIV - 1)))
      w_div_nxt = r_div + DW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_div        <= '0;
      r_sample_en  <= 1'b0;
      r_gain_sel   <= 1'b0;
      r_loop_clear <= 1'b1;
      r_locked     <= 1'b0;
      r_lock_lost  <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_div        <= w_div_nxt;
      r_sample_en  <= (w_next != ST_IDLE) && (w_div_nxt == DW'(SAMPLE_DIV - 1));
      r_gain_sel   <= (w_next == ST_ACQ);
      r_loop_clear <= (w_next == ST_IDLE);
      r_locked     <= (w_next == ST_TRACK);
      r_lock_lost  <= (r_state == ST_TRACK) && (w_next == ST_ACQ);
    end
  end

  assign bus.state      = r_state;
  assign bus.sample_en  = r_sample_en;
  assign bus.gain_sel   = r_gain_sel;
  assign bus.loop_clear = r_loop_clear;
  assign bus.locked     = r_locked;
  assign bus.lock_lost  = r_lock_lost;

endmodule

// File: tb/tb_str_sequencer.sv
// Directed bench for str_sequencer: pacing, lock/loss thresholds, stop and reset.
module tb_str_sequencer;
  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   cnt;

  str_sequencer_if #(.ER_W(32)) bus ();

  str_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [1:0] st, input logic se,
                          input logic gs, input logic lc, input logic lk, input logic ll);
    chk({tag, ".state"}, 32'(bus.state), 32'(st));
    chk({tag, ".sample_en"}, 32'(bus.sample_en), 32'(se));
    chk({tag, ".gain_sel"}, 32'(bus.gain_sel), 32'(gs));
    chk({tag, ".loop_clear"}, 32'(bus.loop_clear), 32'(lc));
    chk({tag, ".locked"}, 32'(bus.locked), 32'(lk));
    chk({tag, ".lock_lost"}, 32'(bus.lock_lost), 32'(ll));
  endtask

  task automatic pulse(input logic [31:0] e);
    bus.ted_out_en = 1'b1;
    bus.er         = e;
    tick();
    bus.ted_out_en = 1'b0;
    bus.er         = '0;
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.ted_out_en = 1'b0;
    bus.er = '0;

    // 1: reset, then idle with start low
    repeat (3) tick();
    chk_outs("reset", 2'b00, 0, 0, 1, 0, 0);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.sample_en) cnt++;
    end
    chk("idle_no_sample", 32'(cnt), 32'd0);
    chk_outs("idle", 2'b00, 0, 0, 1, 0, 0);

    // 2: start -> ACQ, sample_en every 10 clocks
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk_outs("acq_entry", 2'b01, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 30; i++) begin
      tick();
      chk("acq_pace", 32'(bus.sample_en), 32'((i % 10) == 9));
    end

    // 3a: 256 good pulses -> TRACK after the 256th
    for (int i = 1; i <= 256; i++) begin
      pulse(32'd100);
      if (i == 255) chk("lock_255", 32'(bus.state), 32'd1);
    end
    chk_outs("lock_256", 2'b10, bus.sample_en, 0, 0, 1, 0);

    // 4: 15 bad, 1 good, 16 bad -> loss on 16th consecutive bad
    for (int i = 0; i < 15; i++) pulse(-32'sd8000);
    chk("track_15bad", 32'(bus.state), 32'd2);
    pulse(32'd0);
    for (int i = 1; i <= 16; i++) begin
      pulse(-32'sd8000);
      if (i == 15) chk("track_after_gap15", 32'(bus.state), 32'd2);
    end
    chk_outs("loss", 2'b01, bus.sample_en, 1, 0, 0, 1);
    tick();
    chk("lock_lost_one_cycle", 32'(bus.lock_lost), 32'd0);
    chk("acq_after_loss", 32'(bus.state), 32'd1);

    // 3b: bad symbol at 250 -> need 64 consecutive good (pulse 314)
    for (int i = 1; i <= 314; i++) begin
      pulse((i == 250) ? 32'd5000 : 32'd100);
      if (i == 256) chk("delay_256", 32'(bus.state), 32'd1);
      if (i == 313) chk("delay_313", 32'(bus.state), 32'd1);
    end
    chk("delay_314", 32'(bus.state), 32'd2);
    chk("delay_314_locked", 32'(bus.locked), 32'd1);

    // 5: saturated min code and threshold edges
    for (int i = 0; i < 15; i++) pulse(32'h8000_0000);
    chk("min_15", 32'(bus.state), 32'd2);
    pulse(-32'sd4095);
    chk("good_4095", 32'(bus.state), 32'd2);
    for (int i = 0; i < 15; i++) pulse(32'd4096);
    chk("bad_4096_15", 32'(bus.state), 32'd2);
    pulse(32'h8000_0000);
    chk("min_is_bad", 32'(bus.state), 32'd1);
    chk("min_lock_lost", 32'(bus.lock_lost), 32'd1);

    // 6a: stop on the locking pulse wins
    for (int i = 0; i < 255; i++) pulse(32'd100);
    chk("pre_stop", 32'(bus.state), 32'd1);
    bus.stop = 1'b1;
    pulse(32'd100);
    bus.stop = 1'b0;
    chk_outs("stop_on_lock", 2'b00, 0, 0, 1, 0, 0);

    // start and stop together stay in IDLE
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    chk("start_stop_idle", 32'(bus.state), 32'd0);
    bus.stop = 1'b0;
    tick();
    bus.start = 1'b0;
    chk("reacq", 32'(bus.state), 32'd1);
    for (int i = 1; i <= 256; i++) begin
      pulse(32'd7);
      chk("repace", 32'(bus.sample_en), 32'((i % 10) == 9));
    end
    chk("relock", 32'(bus.state), 32'd2);

    // 6b: reset in TRACK
    reset = 1'b1;
    tick();
    chk_outs("reset_in_track", 2'b00, 0, 0, 1, 0, 0);
    reset = 1'b0;
    tick();
    chk("post_reset_idle", 32'(bus.state), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
